// File: rtl/is_div_n_serial.sv
// is_div_n_serial: bit-serial divisibility checker. It consumes an unsigned word MSB-first,
//   STEP bits per cycle, and keeps a running remainder modulo DIVISOR.
// Latency: a word accepted on clock edge t gives out_valid high after edge t+WIDTH/STEP.
//   Best-case throughput is one word every WIDTH/STEP+2 cycles.
// Backpressure: the result is held stable in DONE until out_ready retires it. in_ready stays
//   low from accept until retire. A word offered while busy is not accepted and is not lost.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; a word is accepted when both are high
//   in_data             WIDTH-bit unsigned word under test
//   out_valid/out_ready output handshake; a result is retired when both are high
//   out_rem             in_data mod DIVISOR
//   out_div             1 when out_rem == 0
//   busy                high while a word is in RUN or DONE
module is_div_n_serial #(
  parameter int  WIDTH   = 8,
  parameter int  DIVISOR = 3,
  parameter int  STEP    = 1,
  localparam int REM_W   = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REM_W-1:0] out_rem,
  output logic             out_div,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / STEP;
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  // Width of rem*2^STEP + chunk. Its largest value is (DIVISOR-1)*2^STEP + 2^STEP-1,
  // which is below DIVISOR*2^STEP <= 2^(REM_W+STEP), so the sum cannot overflow.
  localparam int ACC_W  = REM_W + STEP;
  localparam logic [ACC_W-1:0] DIV_C = ACC_W'(DIVISOR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic [STEP-1:0]  chunk;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_mod;
  logic [REM_W-1:0] rem_next;

  assign chunk = shreg[WIDTH-1 -: STEP];

  // Shifting the old residue up by STEP and appending the next STEP bits is
  // the same as a concatenation. A single reduction keeps rem below DIVISOR.
  always_comb begin
    acc      = {rem, chunk};
    acc_mod  = acc % DIV_C;
    rem_next = acc_mod[REM_W-1:0];
  end

  // Single FSM process. in_ready and busy are registered together with state,
  // so they are always the decoded state without any combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      rem       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_rem   <= '0;
      out_div   <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            rem      <= '0;
            cnt      <= CNT_W'(NCHUNK);
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_RUN: begin
          rem   <= rem_next;
          shreg <= shreg << STEP;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_rem   <= rem_next;
            out_div   <= (rem_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          // Words offered here are not accepted. The next accept happens only
          // after the block has returned to IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The running residue is always fully reduced.
  a_rem_reduced: assert property (@(posedge clk) disable iff (rst)
    ACC_W'(rem) < DIV_C);

  // A pending result does not move while the consumer stalls.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (state == S_DONE && !out_ready) |=> (out_valid && $stable(out_rem) && $stable(out_div)));

endmodule

// File: tb/tb_is_div_n_serial.sv
// Testbench for is_div_n_serial.
// It drives one hand-checked directed DUT (W8/D3/S1) for the reset, backpressure and
// mid-RUN reset cases. It also drives a bank of DUTs, one per (DIVISOR, STEP) pair. Each
// bank DUT gets directed words first and then all 256 words. A queue scoreboard and a
// monitor in each bank DUT check the results.
module tb_is_div_n_serial;

  localparam int W    = 8;
  localparam int NCFG = 21;
  localparam int NDIR = 10;

  function automatic int cfg_d(input int i);
    case (i)
      0:          return 3;
      1:          return 7;
      2:          return 1;
      3:          return 5;
      4, 5, 6, 7: return 2;
      8, 9, 10:   return 3;
      11, 12, 13: return 5;
      14, 15, 16: return 7;
      default:    return 10;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0, 2, 4, 11, 14, 17: return 1;
      1, 5, 8, 12, 18:     return 2;
      6, 9, 13, 15, 19:    return 4;
      default:             return 8;
    endcase
  endfunction

  // Directed words per bank config with hand-computed remainders.
  int dir_cfg [NDIR] = '{0,     0,     0,     1,     1,     2,     2,     2,     3,     3};
  int dir_dat [NDIR] = '{8'h99, 8'h64, 8'h03, 8'hFE, 8'h00, 8'hFF, 8'hAB, 8'h00, 8'hFF, 8'h07};
  int dir_rem [NDIR] = '{0,     1,     0,     2,     0,     0,     0,     0,     0,     2};

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int cfg, input string nm, input int act, input int exp);
    total += 1;
    if (act != exp) begin
      bad += 1;
      $display("FAIL cfg=%0d %s: got %0d expected %0d", cfg, nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- bank
  for (genvar g = 0; g < NCFG; g++) begin : gcfg
    localparam int D  = cfg_d(g);
    localparam int S  = cfg_s(g);
    localparam int N  = W / S;
    localparam int RW = (D <= 2) ? 1 : $clog2(D);

    typedef struct {
      int dat;
      int rem;
      int acc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    logic          rst, in_valid, in_ready, out_valid, out_ready, out_div, busy;
    logic [W-1:0]  in_data;
    logic [RW-1:0] out_rem;
    int            cyc     = 0;
    int            n_sent  = 0;
    int            n_ret   = 0;
    logic          holding = 1'b0;
    logic          retired = 1'b0;
    int            h_rem   = 0;
    int            h_div   = 0;

    is_div_n_serial #(.WIDTH(W), .DIVISOR(D), .STEP(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rem   (out_rem),
      .out_div   (out_div),
      .busy      (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input logic [W-1:0] d, input int r);
      int guard;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) chk(g, "accept_timeout", guard, 0);
      // The accept happens at the next rising edge.
      q.push_back('{int'(d), r, cyc + 1});
      n_sent++;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
    endtask

    initial begin
      int guard;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NDIR; i++) begin
        if (dir_cfg[i] == g) send(W'(dir_dat[i]), dir_rem[i]);
      end
      for (int v = 0; v < 256; v++) send(W'(v), v % D);
      guard = 0;
      while ((q.size() != 0 || holding) && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      chk(g, "queue_drained", q.size(), 0);
      chk(g, "handshake_count", n_ret, n_sent);
      ndone += 1;
    end

    // The monitor samples on the falling edge and drives out_ready for the next rising edge.
    always @(negedge clk) begin
      if (rst) begin
        out_ready = 1'b0;
        holding   = 1'b0;
        retired   = 1'b0;
      end else begin
        if (retired) begin
          chk(g, "in_ready_after_retire", int'(in_ready), 1);
          chk(g, "out_valid_after_retire", int'(out_valid), 0);
          retired = 1'b0;
        end else if (out_valid) begin
          if (!holding) begin
            if (q.size() == 0) begin
              chk(g, "unexpected_result", int'(out_valid), 0);
            end else begin
              e = q.pop_front();
              chk(g, "latency", cyc - e.acc, N);
              chk(g, "rem", int'(out_rem), e.rem);
              chk(g, "div", int'(out_div), (e.rem == 0) ? 1 : 0);
              h_rem   = int'(out_rem);
              h_div   = int'(out_div);
              holding = 1'b1;
            end
          end else begin
            chk(g, "rem_stable", int'(out_rem), h_rem);
            chk(g, "div_stable", int'(out_div), h_div);
          end
          chk(g, "in_ready_in_done", int'(in_ready), 0);
          chk(g, "busy_in_done", int'(busy), 1);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          holding = 1'b0;
          retired = 1'b1;
          n_ret++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- directed DUT
  logic         d_rst, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_div, d_busy;
  logic [W-1:0] d_in_data;
  logic [1:0]   d_out_rem;

  is_div_n_serial #(.WIDTH(W), .DIVISOR(3), .STEP(1)) u_dir (
    .clk       (clk),
    .rst       (d_rst),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_data   (d_in_data),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_rem   (d_out_rem),
    .out_div   (d_out_div),
    .busy      (d_busy)
  );

  initial begin
    int t;
    int guard;
    d_rst       = 1'b1;
    d_in_valid  = 1'b0;
    d_in_data   = '0;
    d_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    d_rst = 1'b0;
    @(negedge clk);
    chk(-1, "rst_in_ready", int'(d_in_ready), 1);
    chk(-1, "rst_out_valid", int'(d_out_valid), 0);
    chk(-1, "rst_out_rem", int'(d_out_rem), 0);
    chk(-1, "rst_out_div", int'(d_out_div), 0);
    chk(-1, "rst_busy", int'(d_busy), 0);

    // Holding out_ready high with no pending result must have no effect.
    d_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk(-1, "idle_ready_out_valid", int'(d_out_valid), 0);
    chk(-1, "idle_ready_in_ready", int'(d_in_ready), 1);
    d_out_ready = 1'b0;

    // Hold the output in backpressure while in_valid stays high with different data.
    // 100 % 3 = 1
    d_in_data  = 8'h64;
    d_in_valid = 1'b1;
    @(negedge clk);
    chk(-1, "accept_busy", int'(d_busy), 1);
    chk(-1, "accept_in_ready", int'(d_in_ready), 0);
    d_in_data = 8'h00;
    t = 0;
    while (!d_out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(-1, "latency_0x64", t, 8);
    chk(-1, "rem_0x64", int'(d_out_rem), 1);
    chk(-1, "div_0x64", int'(d_out_div), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(-1, "bp_out_valid", int'(d_out_valid), 1);
      chk(-1, "bp_rem", int'(d_out_rem), 1);
      chk(-1, "bp_div", int'(d_out_div), 0);
      chk(-1, "bp_in_ready", int'(d_in_ready), 0);
      chk(-1, "bp_busy", int'(d_busy), 1);
    end
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    chk(-1, "retire_out_valid", int'(d_out_valid), 0);
    chk(-1, "retire_in_ready", int'(d_in_ready), 1);
    chk(-1, "retire_busy", int'(d_busy), 0);

    // Reset on the third RUN cycle drops the word in flight.
    d_in_data  = 8'hFF;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    chk(-1, "midrun_rst_out_valid", int'(d_out_valid), 0);
    chk(-1, "midrun_rst_busy", int'(d_busy), 0);
    chk(-1, "midrun_rst_in_ready", int'(d_in_ready), 1);
    repeat (10) @(negedge clk);
    chk(-1, "midrun_no_stale_result", int'(d_out_valid), 0);

    // 3 % 3 = 0
    d_in_data  = 8'h03;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    guard = 0;
    while (!d_out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk(-1, "post_rst_valid", int'(d_out_valid), 1);
    chk(-1, "post_rst_rem", int'(d_out_rem), 0);
    chk(-1, "post_rst_div", int'(d_out_div), 1);
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;

    guard = 0;
    while (ndone < NCFG && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk(-1, "all_configs_done", ndone, NCFG);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
